pc_unit: RTL and testbench

Parametrised program-counter unit for the CPU. It owns the PC register and computes every next-PC form: sequential, relative branch, pseudo-direct jump and register jump. It also handles stall, trap redirect and misaligned-target detection, and optionally keeps a return-address stack that checks `jr $ra` targets. It sits at the front of the datapath, feeds instruction memory, and takes its control from the decoder and the ALU branch compare.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_unit_if.sv | 30 +++
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_unit.sv | 116 +++++++++++
 tb/tb_pc_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encoding and default reset/trap vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pcsrc_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of pc_unit control inputs and status outputs, used to group the signals around the unit.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 3
);
  logic             stall;
  logic             trap;
  logic [1:0]       pcsrc;
  logic [WIDTH-1:0] imme;
  logic [25:0]      target;
  logic [WIDTH-1:0] regtarget;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             redirect;
  logic             misalign;
  logic             ras_miss;
  logic [CW-1:0]    ras_count;

  modport master (
    output stall, trap, pcsrc, imme, target, regtarget, push, pop,
    input  pc, pc_plus4, redirect, misalign, ras_miss, ras_count
  );

  modport slave (
    input  stall, trap, pcsrc, imme, target, regtarget, push, pop,
    output pc, pc_plus4, redirect, misalign, ras_miss, ras_count
  );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push at the write pointer, top is the entry just below it,
// count saturates at RAS_DEPTH (oldest entry overwritten once full).
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1),
  localparam int unsigned PW = $clog2(RAS_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx, ptr_inc, wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;

  assign top_idx = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);
  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (push_i && pop_i) begin
      // Simultaneous push/pop replaces the top entry in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en   = 1'b1;
      ptr_d   = ptr_inc;
      count_d = (count_q == CW'(RAS_DEPTH)) ? count_q : count_q + CW'(1);
    end else if (pop_i && (count_q != '0)) begin
      ptr_d   = top_idx;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (wr_en) mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall/trap priority, misaligned-target trap.
// Optional return-address stack check enabled by defining PC_UNIT_RAS_EN.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(TRAP_VECTOR_DEF),
  parameter int unsigned     RAS_DEPTH    = 4,
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Stall,
  input  logic             Trap,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] Imme,
  input  logic [25:0]      Target,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Push,
  input  logic             Pop,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus4,
  output logic             Redirect,
  output logic             Misalign,
  output logic             RAS_Miss,
  output logic [CW-1:0]    RAS_Count
);

  logic [WIDTH-1:0] pc_q, pc_d, br_target, j_target;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic             ras_miss_q, ras_miss_d;
  logic             ras_check_miss;

  assign PC_plus4  = pc_q + WIDTH'(4);
  assign br_target = PC_plus4 + (Imme << 2);
  assign j_target  = {PC_plus4[WIDTH-1:28], Target, 2'b00};

`ifdef PC_UNIT_RAS_EN
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;

  assign ras_push = Push & ~Trap & ~Stall;
  assign ras_pop  = Pop  & ~Trap & ~Stall;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (PC_plus4),
    .top_o       (ras_top),
    .count_o     (ras_count)
  );

  assign ras_check_miss = ras_pop && ((ras_count == '0) || (ras_top != RegTarget));
  assign RAS_Count      = ras_count;
`else
  logic ras_unused;
  assign ras_unused     = Push ^ Pop;
  assign ras_check_miss = 1'b0;
  assign RAS_Count      = '0;
`endif

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    ras_miss_d = ras_check_miss;
    if (Trap) begin
      pc_d       = TRAP_VECTOR;
      redirect_d = 1'b1;
    end else if (!Stall) begin
      redirect_d = (pcsrc_e'(PCSrc) != PC_SEQ);
      unique case (pcsrc_e'(PCSrc))
        PC_SEQ: pc_d = PC_plus4;
        PC_BR:  pc_d = br_target;
        PC_J:   pc_d = j_target;
        PC_JR: begin
          if (RegTarget[1:0] != 2'b00) begin
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
          end else begin
            pc_d = RegTarget;
          end
        end
        default: pc_d = PC_plus4;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  assign PC       = pc_q;
  assign Redirect = redirect_q;
  assign Misalign = misalign_q;
  assign RAS_Miss = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized bench for pc_unit against a queue-based behavioural model.
module tb_pc_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;
  localparam logic [31:0] RST_V  = 32'h0000_3000;
  localparam logic [31:0] TRAP_V = 32'h0000_4180;
  localparam int unsigned DEPTH = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  pc_unit_if #(.WIDTH(W), .CW(CW)) bus ();

  pc_unit #(
    .WIDTH        (W),
    .RESET_VECTOR (RST_V),
    .TRAP_VECTOR  (TRAP_V),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Stall     (bus.stall),
    .Trap      (bus.trap),
    .PCSrc     (bus.pcsrc),
    .Imme      (bus.imme),
    .Target    (bus.target),
    .RegTarget (bus.regtarget),
    .Push      (bus.push),
    .Pop       (bus.pop),
    .PC        (bus.pc),
    .PC_plus4  (bus.pc_plus4),
    .Redirect  (bus.redirect),
    .Misalign  (bus.misalign),
    .RAS_Miss  (bus.ras_miss),
    .RAS_Count (bus.ras_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic        m_redir, m_mis, m_miss;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"}, bus.pc, m_pc);
    chk({tag, "_pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, "_redirect"}, 32'(bus.redirect), 32'(m_redir));
    chk({tag, "_misalign"}, 32'(bus.misalign), 32'(m_mis));
    chk({tag, "_ras_miss"}, 32'(bus.ras_miss), 32'(m_miss));
    chk({tag, "_ras_count"}, 32'(bus.ras_count), 32'(m_ras.size()));
  endtask

  task automatic model_reset();
    m_pc = RST_V; m_redir = 0; m_mis = 0; m_miss = 0;
    m_ras.delete();
  endtask

  // Called between edges: asserts reset, checks the asynchronous effect, releases.
  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, "_async_pc"}, bus.pc, RST_V);
    #2;
    RST_N = 1'b1;
  endtask

  task automatic step(input string tag);
    logic [31:0] npc;
    logic        nred, nmis, nmiss;
    logic [31:0] top;
    npc = m_pc; nred = 0; nmis = 0; nmiss = 0;
    if (bus.trap) begin
      npc = TRAP_V; nred = 1;
    end else if (!bus.stall) begin
      nred = (bus.pcsrc != 2'd0);
      case (bus.pcsrc)
        2'd0: npc = m_pc + 32'd4;
        2'd1: npc = m_pc + 32'd4 + bus.imme * 32'd4;
        2'd2: npc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(bus.target) * 32'd4);
        default: begin
          if (bus.regtarget % 4 != 0) begin npc = TRAP_V; nmis = 1; end
          else npc = bus.regtarget;
        end
      endcase
`ifdef PC_UNIT_RAS_EN
      if (bus.pop) begin
        if (m_ras.size() == 0) nmiss = 1;
        else begin
          top = m_ras[$];
          nmiss = (top != bus.regtarget);
        end
      end
      if (bus.push && bus.pop) begin
        if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 32'd4;
      end else if (bus.push) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
      end else if (bus.pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
`endif
    end
    @(posedge CLK);
    #1;
    m_pc = npc; m_redir = nred; m_mis = nmis; m_miss = nmiss;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.trap = 0; bus.pcsrc = 2'd0; bus.imme = '0;
    bus.target = '0; bus.regtarget = '0; bus.push = 0; bus.pop = 0;
  endtask

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    chk("reset_pc_lit", bus.pc, 32'h3000);
    #1 RST_N = 1'b1;

    // Sequential flow
    repeat (3) step("seq");
    chk("seq_pc_lit", bus.pc, 32'h300C);
    chk("seq_redirect_lit", 32'(bus.redirect), 32'd0);
    step("seq4");

    // Relative branches
    bus.pcsrc = 2'd1; bus.imme = 32'hFFFF_FFFE;
    step("br_back");
    chk("br_back_pc_lit", bus.pc, 32'h300C);
    chk("br_back_redir_lit", 32'(bus.redirect), 32'd1);
    bus.imme = 32'h10;
    step("br_fwd");
    chk("br_fwd_pc_lit", bus.pc, 32'h3050);
    bus.pcsrc = 2'd0;

    // Asynchronous reset between edges
    do_reset("midrst");
    step("midrst_after");
    chk("midrst_after_lit", bus.pc, 32'h3004);

    // Jump and misaligned register jump
    do_reset("rst_j");
    bus.pcsrc = 2'd2; bus.target = 26'h40;
    step("jump");
    chk("jump_pc_lit", bus.pc, 32'h100);
    bus.pcsrc = 2'd3; bus.regtarget = 32'h3002;
    step("jr_mis");
    chk("jr_mis_pc_lit", bus.pc, 32'h4180);
    chk("jr_mis_flag_lit", 32'(bus.misalign), 32'd1);
    chk("jr_mis_redir_lit", 32'(bus.redirect), 32'd1);
    bus.pcsrc = 2'd0;
    step("jr_mis_clear");

    // Stall hold, trap overrides stall
    do_reset("rst_stall");
    repeat (2) step("pre_stall");
    bus.stall = 1;
    repeat (4) step("stall");
    chk("stall_pc_lit", bus.pc, 32'h3008);
    bus.trap = 1;
    step("trap_in_stall");
    chk("trap_pc_lit", bus.pc, 32'h4180);
    bus.trap = 0; bus.stall = 0;

`ifdef PC_UNIT_RAS_EN
    do_reset("rst_ras");
    bus.push = 1;
    step("ras_push1");
    chk("ras_push1_cnt_lit", 32'(bus.ras_count), 32'd1);
    bus.push = 0; bus.pop = 1; bus.pcsrc = 2'd3; bus.regtarget = 32'h3004;
    step("ras_pop1");
    chk("ras_pop1_miss_lit", 32'(bus.ras_miss), 32'd0);
    chk("ras_pop1_cnt_lit", 32'(bus.ras_count), 32'd0);
    bus.pop = 0; bus.pcsrc = 2'd0;
    bus.push = 1;
    repeat (5) step("ras_fill");
    chk("ras_full_cnt_lit", 32'(bus.ras_count), 32'd4);
    bus.push = 0; bus.pop = 1; bus.regtarget = 32'h2000;
    repeat (5) step("ras_drain");
    chk("ras_empty_miss_lit", 32'(bus.ras_miss), 32'd1);
    bus.pop = 0;
`endif

    // Randomized traffic
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      bus.stall  = ($urandom_range(0, 9) == 0);
      bus.trap   = ($urandom_range(0, 19) == 0);
      bus.pcsrc  = 2'($urandom_range(0, 3));
      bus.imme   = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      bus.target = 26'($urandom);
      bus.push   = ($urandom_range(0, 3) == 0);
      bus.pop    = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 3);
      if (r == 0) bus.regtarget = $urandom | 32'd1;
      else bus.regtarget = $urandom & ~32'd3;
`ifdef PC_UNIT_RAS_EN
      if (r == 1 && m_ras.size() > 0) bus.regtarget = m_ras[m_ras.size()-1];
`endif
      step("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
